// File: rtl/dec_ex_stage.sv
// Decode + execute slice: splits IR, latches operands into DEC/EX, then registers ALU/branch results.
// Instruction fields use conventional [31:0] indexing: MSB-first field IR[0:5] is IR_IN[31:26], etc.
module dec_ex_stage #(
    parameter int W = 32
) (
    input  logic         CLOCK,
    input  logic         RESET,
    input  logic [31:0]  IR_IN,
    input  logic [W-1:0] PC_IN,
    input  logic [W-1:0] A_VAL_IN,
    input  logic [W-1:0] B_VAL_IN,
    output logic [4:0]   A_REG_ADD,
    output logic [4:0]   B_REG_ADD,
    output logic [W-1:0] ALU_OUT,
    output logic [W-1:0] MEM_DATA,
    output logic         COND,
    output logic [5:0]   OP_OUT,
    output logic [5:0]   FC_OUT,
    output logic [4:0]   D_REG_ADD_OUT,
    output logic         STALL_OUT,
    output logic         STALL_IF_OUT
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000, OP_J    = 6'b000010, OP_BEQZ = 6'b000100,
        OP_BNEZ  = 6'b000101, OP_ADDI = 6'b001000, OP_ANDI = 6'b001100,
        OP_ORI   = 6'b001101, OP_XORI = 6'b001110, OP_LW   = 6'b100011,
        OP_SW    = 6'b101011
    } opcode_e;

    typedef enum logic [5:0] {
        FC_SLL = 6'b000100, FC_SRL = 6'b000110, FC_SRA = 6'b000111,
        FC_ADD = 6'b100000, FC_SUB = 6'b100010, FC_AND = 6'b100100,
        FC_OR  = 6'b100101, FC_XOR = 6'b100110, FC_SLT = 6'b101010
    } funct_e;

    logic [5:0] ir_op, ir_fc;
    logic [4:0] ir_rt, ir_rd;

    assign ir_op     = IR_IN[31:26];
    assign ir_fc     = IR_IN[5:0];
    assign ir_rt     = IR_IN[20:16];
    assign ir_rd     = IR_IN[15:11];
    assign A_REG_ADD = IR_IN[25:21];
    assign B_REG_ADD = IR_IN[20:16];

    // ---------------- decode ----------------
    logic       valid_d, sif_d;
    logic [4:0] dreg_d;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        valid_d = 1'b1;
        sif_d   = 1'b0;
        dreg_d  = 5'd0;
        case (ir_op)
            OP_RTYPE: begin
                dreg_d = ir_rd;
                case (ir_fc)
                    FC_ADD, FC_SUB, FC_AND, FC_OR, FC_XOR,
                    FC_SLT, FC_SLL, FC_SRL, FC_SRA: valid_d = 1'b1;
                    default:                        valid_d = 1'b0;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LW: dreg_d = ir_rt;
            OP_SW:                                    dreg_d = 5'd0;
            OP_BEQZ, OP_BNEZ, OP_J:                   sif_d  = 1'b1;
            default:                                  valid_d = 1'b0;
        endcase
        if (IR_IN == 32'd0) valid_d = 1'b0;
        if (!valid_d) begin
            dreg_d = 5'd0;
            sif_d  = 1'b0;
        end
    end

    // ---------------- DEC/EX register ----------------
    logic [5:0]   op_q, fc_q;
    logic [4:0]   dreg_q;
    logic         bub_q, sif_q;
    logic [25:0]  imm_q;
    logic [W-1:0] a_q, b_q, pc_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            op_q   <= '0;
            fc_q   <= '0;
            dreg_q <= '0;
            bub_q  <= 1'b1;
            sif_q  <= 1'b0;
            imm_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            pc_q   <= '0;
        end else begin
            op_q   <= ir_op;
            fc_q   <= ir_fc;
            dreg_q <= dreg_d;
            bub_q  <= !valid_d;
            sif_q  <= sif_d;
            imm_q  <= IR_IN[25:0];
            a_q    <= A_VAL_IN;
            b_q    <= B_VAL_IN;
            pc_q   <= PC_IN;
        end
    end

    // ---------------- execute ----------------
    logic [W-1:0] simm, zimm, joff, alu_d;
    logic [4:0]   shamt;
    logic         cond_d;

    assign simm  = {{(W-16){imm_q[15]}}, imm_q[15:0]};
    assign zimm  = {{(W-16){1'b0}}, imm_q[15:0]};
    assign joff  = {{(W-26){imm_q[25]}}, imm_q};
    assign shamt = b_q[4:0];

    always_comb begin
        alu_d  = '0;
        cond_d = 1'b0;
        if (!bub_q) begin
            case (op_q)
                OP_RTYPE: begin
                    case (fc_q)
                        FC_ADD:  alu_d = a_q + b_q;
                        FC_SUB:  alu_d = a_q - b_q;
                        FC_AND:  alu_d = a_q & b_q;
                        FC_OR:   alu_d = a_q | b_q;
                        FC_XOR:  alu_d = a_q ^ b_q;
                        FC_SLT:  alu_d = {{(W-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                        FC_SLL:  alu_d = a_q << shamt;
                        FC_SRL:  alu_d = a_q >> shamt;
                        FC_SRA:  alu_d = $signed(a_q) >>> shamt;
                        default: alu_d = '0;
                    endcase
                end
                OP_ADDI, OP_LW, OP_SW: alu_d = a_q + simm;
                OP_ANDI: alu_d = a_q & zimm;
                OP_ORI:  alu_d = a_q | zimm;
                OP_XORI: alu_d = a_q ^ zimm;
                OP_BEQZ: begin
                    alu_d  = pc_q + simm;
                    cond_d = (a_q == '0);
                end
                OP_BNEZ: begin
                    alu_d  = pc_q + simm;
                    cond_d = (a_q != '0);
                end
                OP_J: begin
                    alu_d  = pc_q + joff;
                    cond_d = 1'b1;
                end
                default: alu_d = '0;
            endcase
        end
    end

    // ---------------- EX output bank ----------------
    logic [W-1:0] alu_q, mem_q;
    logic         cond_q, stall_q;
    logic [5:0]   op_ex_q, fc_ex_q;
    logic [4:0]   dreg_ex_q;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            alu_q     <= '0;
            mem_q     <= '0;
            cond_q    <= 1'b0;
            op_ex_q   <= '0;
            fc_ex_q   <= '0;
            dreg_ex_q <= '0;
            stall_q   <= 1'b1;
        end else begin
            alu_q     <= alu_d;
            mem_q     <= b_q;
            cond_q    <= cond_d;
            op_ex_q   <= op_q;
            fc_ex_q   <= fc_q;
            dreg_ex_q <= dreg_q;
            stall_q   <= bub_q;
        end
    end

    assign ALU_OUT       = alu_q;
    assign MEM_DATA      = mem_q;
    assign COND          = cond_q;
    assign OP_OUT        = op_ex_q;
    assign FC_OUT        = fc_ex_q;
    assign D_REG_ADD_OUT = dreg_ex_q;
    assign STALL_OUT     = stall_q;
    // Control-hazard request comes straight from DEC/EX so fetch holds one clock after the branch.
    assign STALL_IF_OUT  = sif_q;

endmodule

// File: tb/tb_dec_ex_stage.sv
// Self-checking bench for dec_ex_stage: directed cases plus random instructions against a
// behavioural model; EX outputs compared 2 clocks after presentation, fetch hold after 1.
module tb_dec_ex_stage;

    logic        CLOCK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] IR_IN = '0, PC_IN = '0, A_VAL_IN = '0, B_VAL_IN = '0;
    logic [4:0]  A_REG_ADD, B_REG_ADD, D_REG_ADD_OUT;
    logic [31:0] ALU_OUT, MEM_DATA;
    logic        COND, STALL_OUT, STALL_IF_OUT;
    logic [5:0]  OP_OUT, FC_OUT;

    dec_ex_stage #(.W(32)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .IR_IN(IR_IN), .PC_IN(PC_IN),
        .A_VAL_IN(A_VAL_IN), .B_VAL_IN(B_VAL_IN),
        .A_REG_ADD(A_REG_ADD), .B_REG_ADD(B_REG_ADD),
        .ALU_OUT(ALU_OUT), .MEM_DATA(MEM_DATA), .COND(COND),
        .OP_OUT(OP_OUT), .FC_OUT(FC_OUT), .D_REG_ADD_OUT(D_REG_ADD_OUT),
        .STALL_OUT(STALL_OUT), .STALL_IF_OUT(STALL_IF_OUT)
    );

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [31:0] alu, mem;
        logic [5:0]  op, fc;
        logic [4:0]  dreg;
        bit          cond, stall, sif, mval;
    } exp_t;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t p1, p2, rst_e;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: straight from the instruction-set rules, integer arithmetic on whole words.
    function automatic exp_t model(input logic [31:0] ir, pc, a, b);
        exp_t        e;
        int unsigned op, fc, rt, rd, sh;
        int          s16, s26;
        logic [31:0] simm, zimm, joff, r;
        logic [4:0]  dst;
        bit          ok, br, c;
        op = ir / 2**26;
        fc = ir % 64;
        rt = (ir / 2**16) % 32;
        rd = (ir / 2**11) % 32;
        sh = b % 32;
        s16 = int'(ir % 65536);
        if (s16 >= 32768) s16 -= 65536;
        s26 = int'(ir % 2**26);
        if (s26 >= 2**25) s26 -= 2**26;
        simm = s16;
        zimm = ir % 65536;
        joff = s26;
        ok = 1; br = 0; c = 0; r = 0; dst = 0;
        case (op)
            0: begin
                dst = 5'(rd);
                case (fc)
                    32: r = a + b;
                    34: r = a - b;
                    36: r = a & b;
                    37: r = a | b;
                    38: r = a ^ b;
                    42: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    4:  r = a << sh;
                    6:  r = a >> sh;
                    7:  r = $signed(a) >>> sh;
                    default: ok = 0;
                endcase
            end
            8:  begin r = a + simm; dst = 5'(rt); end
            12: begin r = a & zimm; dst = 5'(rt); end
            13: begin r = a | zimm; dst = 5'(rt); end
            14: begin r = a ^ zimm; dst = 5'(rt); end
            35: begin r = a + simm; dst = 5'(rt); end
            43: r = a + simm;
            4:  begin r = pc + simm; c = (a == 0); br = 1; end
            5:  begin r = pc + simm; c = (a != 0); br = 1; end
            2:  begin r = pc + joff; c = 1;        br = 1; end
            default: ok = 0;
        endcase
        if (ir == 0) ok = 0;
        e.op = 6'(op);
        e.fc = 6'(fc);
        e.alu   = ok ? r : 32'd0;
        e.cond  = ok ? c : 1'b0;
        e.dreg  = ok ? dst : 5'd0;
        e.stall = !ok;
        e.sif   = ok ? br : 1'b0;
        e.mem   = b;
        e.mval  = ok;
        return e;
    endfunction

    function automatic logic [31:0] enc_r(input int rs, rt, rd, fc);
        return 32'((rs << 21) | (rt << 16) | (rd << 11) | fc);
    endfunction

    function automatic logic [31:0] enc_i(input int op, rs, rt, imm);
        return 32'((op << 26) | (rs << 21) | (rt << 16) | (imm & 'hFFFF));
    endfunction

    task automatic check_ex(input exp_t e);
        check("alu_out", ALU_OUT, e.alu);
        if (e.mval) check("mem_data", MEM_DATA, e.mem);
        check("cond", 32'(COND), 32'(e.cond));
        check("op_out", 32'(OP_OUT), 32'(e.op));
        check("fc_out", 32'(FC_OUT), 32'(e.fc));
        check("d_reg_add", 32'(D_REG_ADD_OUT), 32'(e.dreg));
        check("stall_out", 32'(STALL_OUT), 32'(e.stall));
    endtask

    // One clock: check results of earlier instructions, then present a new one.
    task automatic step(input logic [31:0] ir, pc, a, b);
        @(negedge CLOCK);
        check_ex(p2);
        check("stall_if", 32'(STALL_IF_OUT), 32'(p1.sif));
        IR_IN = ir; PC_IN = pc; A_VAL_IN = a; B_VAL_IN = b;
        #1;
        check("a_reg_add", 32'(A_REG_ADD), (ir / 2**21) % 32);
        check("b_reg_add", 32'(B_REG_ADD), (ir / 2**16) % 32);
        p2 = p1;
        p1 = model(ir, pc, a, b);
    endtask

    // Pulse reset between edges: outputs must clear at once, in-flight work is dropped.
    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b1;
        #1;
        check_ex(rst_e);
        check("rst_stall_if", 32'(STALL_IF_OUT), 32'd0);
        #1;
        RESET = 1'b0;
        p2 = rst_e;
        p1 = model(IR_IN, PC_IN, A_VAL_IN, B_VAL_IN);
    endtask

    int unsigned valid_ops[10] = '{0, 2, 4, 5, 8, 12, 13, 14, 35, 43};
    int unsigned valid_fcs[9]  = '{4, 6, 7, 32, 34, 36, 37, 38, 42};

    initial begin
        logic [31:0] ir, a;
        int unsigned op;
        rst_e = '{alu: 32'd0, mem: 32'd0, op: 6'd0, fc: 6'd0, dreg: 5'd0,
                  cond: 1'b0, stall: 1'b1, sif: 1'b0, mval: 1'b1};
        repeat (2) @(posedge CLOCK);
        do_reset();

        // Directed cases
        step(32'h0043_0820, 32'h4, 32'd5, 32'd7);                   // ADD r1=r2+r3
        step(enc_i(8, 2, 4, 'hFFFF), 32'h8, 32'd1, 32'd0);          // ADDI -1
        step(enc_i(13, 0, 5, 'h8000), 32'hC, 32'd0, 32'd9);         // ORI zero-extend
        step(enc_i(43, 6, 7, 8), 32'h10, 32'h100, 32'hDEAD_BEEF);   // SW
        step(enc_i(4, 1, 0, 'hFFF8), 32'h20, 32'd0, 32'd0);         // BEQZ taken
        step(enc_i(4, 1, 0, 'hFFF8), 32'h20, 32'd3, 32'd0);         // BEQZ not taken
        step(32'h0800_0040, 32'h10, 32'd0, 32'd0);                  // J +0x40
        step(32'h0, 32'h14, 32'd0, 32'd0);                          // bubble
        step(enc_r(1, 2, 3, 7), 32'h18, 32'h8000_0000, 32'd4);      // SRA
        step(enc_r(1, 2, 3, 42), 32'h1C, 32'hFFFF_FFFF, 32'd1);     // SLT
        step(enc_r(1, 2, 0, 32), 32'h20, 32'd1, 32'd2);             // ADD with RD=0
        step(enc_i(5, 1, 0, 'h0010), 32'h24, 32'd7, 32'd0);         // BNEZ taken
        step(enc_r(1, 2, 3, 9), 32'h28, 32'd1, 32'd2);              // unknown FC
        step(enc_i(63, 1, 2, 5), 32'h2C, 32'd1, 32'd2);             // unknown OP
        step(32'h0043_0820, 32'h30, 32'd5, 32'd7);
        step(enc_i(8, 2, 4, 3), 32'h34, 32'd10, 32'd0);
        do_reset();                                                 // drops both in-flight
        step(enc_r(2, 3, 4, 34), 32'h38, 32'd3, 32'd5);             // SUB wraps

        // Random instructions
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                ir = $urandom;
            end else begin
                op = valid_ops[$urandom_range(0, 9)];
                if (op == 0) begin
                    ir = enc_r(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                               int'($urandom_range(0, 31)), int'(valid_fcs[$urandom_range(0, 8)]));
                    ir = ir | ($urandom_range(0, 31) << 6);
                end else begin
                    ir = (op << 26) | ($urandom & 32'h03FF_FFFF);
                end
            end
            a = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            step(ir, $urandom & 32'hFFFF_FFFC, a, $urandom);
            if (i == 150) do_reset();
        end

        step(32'h0, 32'h0, 32'd0, 32'd0);
        step(32'h0, 32'h0, 32'd0, 32'd0);
        step(32'h0, 32'h0, 32'd0, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dec_ex_stage.md
Name: dec_ex_stage

Overview:
- Decode plus execute slice of the 5-stage 32-bit integer pipeline. Sits between the IF/DEC register and the EX/MEM register.
- Splits the instruction word, drives register-file read addresses combinationally, and latches decoded fields plus operand values into an internal DEC/EX register.
- Computes the ALU result, store data and branch condition into a registered EX output bank.
- The clock comes from the bench clock generator (`clkgen`); no clock generation is done inside this block.

Parameters:
- W, 32, datapath width. Vectors are numbered [0:W-1]; bit 0 is the MSB.

Ports:
- CLOCK in 1: single clock, rising edge.
- RESET in 1: asynchronous, active-high reset.
- IR_IN in 32: instruction from IF/DEC.
- PC_IN in 32: address of the next sequential instruction (fetch PC+4).
- A_VAL_IN in 32: register-file read data for A_REG_ADD.
- B_VAL_IN in 32: register-file read data for B_REG_ADD.
- A_REG_ADD out 5: combinational, IR_IN[6:10].
- B_REG_ADD out 5: combinational, IR_IN[11:15].
- ALU_OUT out 32: registered ALU result, address or branch target.
- MEM_DATA out 32: registered store data.
- COND out 1: registered branch/jump taken.
- OP_OUT out 6: registered opcode.
- FC_OUT out 6: registered function code.
- D_REG_ADD_OUT out 5: registered destination register; 0 means no writeback.
- STALL_OUT out 1: registered bubble flag.
- STALL_IF_OUT out 1: registered fetch-hold request (control hazard).

Behaviour:
- Field split: OP=IR[0:5], RS=IR[6:10], RT=IR[11:15], RD=IR[16:20], FC=IR[26:31].
- IMM = sign-extend IR[16:31]; ZIMM = zero-extend IR[16:31]; JOFF = sign-extend IR[6:31].
- Destination register:
  - RD for OP=000000.
  - RT for ADDI, ANDI, ORI, XORI, LW.
  - 0 for SW, branches, J and bubbles.
- R-type (OP=000000), selected by FC:
  - 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR.
  - 101010 SLT: signed compare, result 1/0.
  - 000100 SLL, 000110 SRL, 000111 SRA: shift A by B[27:31].
- I-type, selected by OP:
  - 001000 ADDI: A+IMM. 001100 ANDI: A&ZIMM. 001101 ORI: A|ZIMM. 001110 XORI: A^ZIMM.
  - 100011 LW: A+IMM.
  - 101011 SW: A+IMM, MEM_DATA=B.
  - 000100 BEQZ: ALU=PC_IN+IMM, COND=(A==0).
  - 000101 BNEZ: ALU=PC_IN+IMM, COND=(A!=0).
  - 000010 J: ALU=PC_IN+JOFF, COND=1.
- Arithmetic: all add/sub wraps mod 2^32; overflow is ignored; no traps.
- MEM_DATA = B for every valid instruction; only SW consumes it.
- Bubble: IR_IN==0, an unknown OP, or an unknown FC under OP=000000. A bubble forces:
  - STALL=1, D_REG_ADD=0, COND=0, ALU=0;
  - OP/FC still pass through.
- STALL_IF = 1 for BEQZ, BNEZ and J (valid instructions only), else 0.
- Pipeline timing:
  - Edge N latches IR-derived fields, A_VAL_IN and B_VAL_IN into the DEC/EX register.
  - Edge N+1 updates all EX outputs. IR to ALU_OUT latency is 2 clocks.
  - A_REG_ADD and B_REG_ADD have 0 latency.
- STALL_IF_OUT is taken from the DEC/EX register, so it asserts 1 clock after the branch is presented.
- Throughput: one instruction per clock; no backpressure input.
- Reset (asynchronous, immediate, both banks):
  - All 32-bit outputs 0, OP_OUT=0, FC_OUT=0, D_REG_ADD_OUT=0, COND=0.
  - STALL_OUT=1, STALL_IF_OUT=0.
  - Deassertion takes effect at the next rising edge.
  - Asserting reset mid-stream discards both in-flight instructions.
- Register 0: the block does not special-case reads of r0; the register file returns 0. An explicit RD=0 still yields D_REG_ADD_OUT=0.
- Back-to-back instructions are independent; there is no forwarding in this block.

Test Plan:
- Reset: assert RESET mid-run -> outputs clear immediately; STALL_OUT=1, D_REG_ADD_OUT=0. First valid result appears 2 clocks after release.
- ADD: IR=0x00430820 (RS=2, RT=3, RD=1, FC=100000), A=5, B=7 -> A_REG_ADD=2, B_REG_ADD=3 same cycle; 2 clocks later ALU_OUT=0x0000000C, D_REG_ADD_OUT=1, STALL_OUT=0.
- Immediate sign handling: ADDI with IMM=0xFFFF, A=1 -> ALU_OUT=0. ORI with 0x8000, A=0 -> 0x00008000.
- SW: A=0x100, IMM=8, B=0xDEADBEEF -> ALU_OUT=0x108, MEM_DATA=0xDEADBEEF, D_REG_ADD_OUT=0.
- Branches:
  - BEQZ, PC_IN=0x20, IMM=0xFFF8, A=0 -> ALU_OUT=0x18, COND=1. STALL_IF_OUT=1 one clock after presentation.
  - Same with A=3 -> COND=0.
  - J, PC_IN=0x10, offset +0x40 -> ALU_OUT=0x50, COND=1.
- Bubble and shifts:
  - IR=0 -> STALL_OUT=1, D_REG_ADD_OUT=0, COND=0.
  - SRA A=0x80000000, B=4 -> 0xF8000000.
  - SLT A=-1, B=1 -> 1.
